// File: rtl/sm83_int_ctrl.sv
// -----------------------------------------------------------------------------
// sm83_int_ctrl
//   Interrupt controller for the SM83 core dispatch interface. Holds IF and IE,
//   latches peripheral requests into IF, raises int_pending_o (also the HALT
//   wake) and resolves the interrupt vector during the core's dispatch.
//
//   State table
//     IDLE     | waiting for dispatch_start_i
//     WAIT_SEL | dispatch in progress, waiting for dispatch_sel_i to resolve
//
//   Ports
//     clk_i, rst_n_i       clock, asynchronous active-low reset
//     addr_i, wdata_i      CPU bus address / write data
//     wr_i, rd_i           write strobe / read strobe
//     rdata_o              registered read data (0x00 outside IF/IE)
//     irq_req_i            peripheral request lines (bit 0 = VBlank, highest)
//     int_pending_o        |(IE & IF), independent of IME
//     dispatch_start_i     core begins interrupt dispatch
//     dispatch_sel_i       core vector-resolve cycle
//     dispatch_busy_o      high while in WAIT_SEL
//     vec_valid_o          one-cycle pulse, int_vector_o is valid
//     int_vector_o         resolved vector, held until the next resolve
//
//   Build option
//     INTC_REQ_EDGE_EN : requests set IF on rising edges of irq_req_i only.
//                        Undefined: irq_req_i is sampled as a level each cycle.
// -----------------------------------------------------------------------------
module sm83_int_ctrl #(
  parameter int          NUM_IRQ = 5,
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [15:0]        addr_i,
  input  logic [7:0]         wdata_i,
  input  logic               wr_i,
  input  logic               rd_i,
  output logic [7:0]         rdata_o,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  output logic               int_pending_o,
  input  logic               dispatch_start_i,
  input  logic               dispatch_sel_i,
  output logic               dispatch_busy_o,
  output logic               vec_valid_o,
  output logic [15:0]        int_vector_o
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_SEL = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   if_q, if_d;
  logic [7:0]           ie_q, ie_d;
  logic [7:0]           rdata_q, rdata_d;
  logic [15:0]          vec_q, vec_d;
  logic                 vec_valid_q, vec_valid_d;

  logic [NUM_IRQ-1:0]   req_set;
  logic [NUM_IRQ-1:0]   pend;
  logic [NUM_IRQ-1:0]   clr_mask;
  logic [2:0]           idx;
  logic [4:0]           if_pad;
  logic                 wr_if, wr_ie;

  assign wr_if = wr_i && (addr_i == IF_ADDR);
  assign wr_ie = wr_i && (addr_i == IE_ADDR);

`ifdef INTC_REQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_req_q;

  // History resets to 0, so a line already high at reset release is an edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) irq_req_q <= '0;
    else          irq_req_q <= irq_req_i;
  end

  assign req_set = irq_req_i & ~irq_req_q;
`else
  assign req_set = irq_req_i;
`endif

  // Pending set uses register values, so a same-cycle write cannot alter the
  // source being resolved; that is what lets a mid-dispatch IE/IF change
  // cancel (or redirect) the dispatch.
  assign pend          = ie_q[NUM_IRQ-1:0] & if_q;
  assign int_pending_o = |pend;

  always_comb begin
    idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) idx = 3'(i);
    end
  end

  always_comb begin
    if_pad              = 5'b0;
    if_pad[NUM_IRQ-1:0] = if_q;
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    vec_valid_d = 1'b0;
    clr_mask    = '0;
    case (state_q)
      IDLE: begin
        if (dispatch_start_i) state_d = WAIT_SEL;
      end
      WAIT_SEL: begin
        if (dispatch_sel_i) begin
          vec_valid_d = 1'b1;
          state_d     = IDLE;
          if (|pend) begin
            clr_mask = NUM_IRQ'(1) << idx;
            vec_d    = 16'h0040 + {10'd0, idx, 3'd0};
          end else begin
            vec_d    = 16'h0000;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write first, then the dispatch clear, then requests on top: a request
  // always survives a same-cycle clear or write.
  always_comb begin
    if_d = wr_if ? wdata_i[NUM_IRQ-1:0] : if_q;
    if_d = (if_d & ~clr_mask) | req_set;
    ie_d = wr_ie ? wdata_i : ie_q;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_i) begin
      if (addr_i == IF_ADDR)      rdata_d = {3'b111, if_pad};
      else if (addr_i == IE_ADDR) rdata_d = ie_q;
      else                        rdata_d = 8'h00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      if_q        <= '0;
      ie_q        <= 8'h00;
      rdata_q     <= 8'h00;
      vec_q       <= 16'h0000;
      vec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_q        <= if_d;
      ie_q        <= ie_d;
      rdata_q     <= rdata_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
    end
  end

  assign rdata_o         = rdata_q;
  assign dispatch_busy_o = (state_q == WAIT_SEL);
  assign vec_valid_o     = vec_valid_q;
  assign int_vector_o    = vec_q;

endmodule

// File: tb/tb_sm83_int_ctrl.sv
module tb_sm83_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  rdata;
  logic [4:0]  irq_req = 5'h00;
  logic        int_pending;
  logic        dstart = 1'b0;
  logic        dsel = 1'b0;
  logic        dbusy;
  logic        vvalid;
  logic [15:0] vec;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sm83_int_ctrl dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .wr_i             (wr),
    .rd_i             (rd),
    .rdata_o          (rdata),
    .irq_req_i        (irq_req),
    .int_pending_o    (int_pending),
    .dispatch_start_i (dstart),
    .dispatch_sel_i   (dsel),
    .dispatch_busy_o  (dbusy),
    .vec_valid_o      (vvalid),
    .int_vector_o     (vec)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: registers as plain bytes, dispatch as a busy flag.
  logic [7:0]  m_if, m_ie, m_rdata;
  logic [15:0] m_vec;
  logic        m_vv, m_busy;
  logic [4:0]  m_prev;

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] p, nif, clr, rs;
    if (!rst_n) begin
      m_if <= 0; m_ie <= 0; m_rdata <= 0; m_vec <= 0; m_vv <= 0; m_busy <= 0; m_prev <= 0;
    end else begin
      p   = m_ie & m_if & 8'h1F;
      nif = (wr && addr == 16'hFF0F) ? (wdata & 8'h1F) : m_if;
      clr = 8'h00;
      if (m_busy && dsel) begin
        m_vv   <= 1'b1;
        m_busy <= 1'b0;
        m_vec  <= 16'h0000;
        for (int i = 4; i >= 0; i--) begin
          if (p[i]) begin
            clr   = 8'(1 << i);
            m_vec <= 16'(64 + 8 * i);
          end
        end
      end else begin
        m_vv <= 1'b0;
        if (!m_busy && dstart) m_busy <= 1'b1;
      end
`ifdef INTC_REQ_EDGE_EN
      rs = {3'b000, irq_req & ~m_prev};
`else
      rs = {3'b000, irq_req};
`endif
      m_if   <= (nif & ~clr) | rs;
      if (wr && addr == 16'hFFFF) m_ie <= wdata;
      if (rd) m_rdata <= (addr == 16'hFF0F) ? (8'hE0 | m_if) :
                         (addr == 16'hFFFF) ? m_ie : 8'h00;
      m_prev <= irq_req;
    end
  end

  always @(negedge clk) begin
    chk("int_pending", {15'b0, int_pending}, {15'b0, |(m_ie & m_if & 8'h1F)});
    chk("dispatch_busy", {15'b0, dbusy}, {15'b0, m_busy});
    chk("vec_valid", {15'b0, vvalid}, {15'b0, m_vv});
    chk("int_vector", vec, m_vec);
    chk("rdata", {8'h00, rdata}, {8'h00, m_rdata});
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [15:0] a, input logic [7:0] exp, input string name);
    addr = a; rd = 1'b1;
    step();
    rd = 1'b0;
    chk(name, {8'h00, rdata}, {8'h00, exp});
  endtask

  initial begin
    @(negedge clk);
    chk("reset_vec_valid", {15'b0, vvalid}, 16'h0);
    chk("reset_pending", {15'b0, int_pending}, 16'h0);
    chk("reset_vector", vec, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    rd_reg(16'hFF0F, 8'hE0, "reset_if_read");
    rd_reg(16'hFFFF, 8'h00, "reset_ie_read");
    rd_reg(16'h1234, 8'h00, "other_addr_read");

    wr_reg(16'hFFFF, 8'h05);
    irq_req = 5'h04;
    step();
    irq_req = 5'h00;
    chk("timer_pending", {15'b0, int_pending}, 16'h1);
    rd_reg(16'hFF0F, 8'hE4, "timer_if_read");
    rd_reg(16'hFFFF, 8'h05, "ie_read");

    // Priority dispatch: IF=05, IE=1F
    wr_reg(16'hFF0F, 8'h05);
    wr_reg(16'hFFFF, 8'h1F);
    dstart = 1'b1; step(); dstart = 1'b0;
    chk("busy_after_start", {15'b0, dbusy}, 16'h1);
    dsel = 1'b1; step(); dsel = 1'b0;
    chk("vec_vblank", vec, 16'h0040);
    chk("vv_pulse", {15'b0, vvalid}, 16'h1);
    step();
    chk("vv_one_cycle", {15'b0, vvalid}, 16'h0);
    chk("vec_held", vec, 16'h0040);
    rd_reg(16'hFF0F, 8'hE4, "if_after_vblank");
    dstart = 1'b1; step(); dstart = 1'b0;
    dsel = 1'b1; step(); dsel = 1'b0;
    chk("vec_timer", vec, 16'h0050);
    rd_reg(16'hFF0F, 8'hE0, "if_after_timer");
    chk("no_pending", {15'b0, int_pending}, 16'h0);

    // dispatch_sel in IDLE is ignored
    dsel = 1'b1; step(); dsel = 1'b0;
    chk("sel_idle_ignored", {15'b0, vvalid}, 16'h0);

    // Cancel: IE cleared mid-dispatch
    wr_reg(16'hFF0F, 8'h01);
    wr_reg(16'hFFFF, 8'h01);
    dstart = 1'b1; step(); dstart = 1'b0;
    wr_reg(16'hFFFF, 8'h00);
    dsel = 1'b1; step(); dsel = 1'b0;
    chk("vec_cancel", vec, 16'h0000);
    chk("vv_cancel", {15'b0, vvalid}, 16'h1);
    rd_reg(16'hFF0F, 8'hE1, "if_after_cancel");

    // Redirect: IE written to 03 during WAIT_SEL with IF=02
    wr_reg(16'hFF0F, 8'h02);
    dstart = 1'b1; step(); dstart = 1'b0;
    wr_reg(16'hFFFF, 8'h03);
    dsel = 1'b1; step(); dsel = 1'b0;
    chk("vec_stat", vec, 16'h0048);
    rd_reg(16'hFF0F, 8'hE0, "if_after_stat");

    // Collision: resolve bit 0 while irq_req[0] rises
    wr_reg(16'hFF0F, 8'h01);
    dstart = 1'b1; step(); dstart = 1'b0;
    dsel = 1'b1; irq_req = 5'h01; step(); dsel = 1'b0; irq_req = 5'h00;
    chk("vec_collision", vec, 16'h0040);
    rd_reg(16'hFF0F, 8'hE1, "if_collision");

    // Held STAT request vs CPU clear
    irq_req = 5'h02;
    step(); step();
    wr_reg(16'hFF0F, 8'h00);
    step();
`ifdef INTC_REQ_EDGE_EN
    rd_reg(16'hFF0F, 8'hE0, "held_level_clear");
`else
    rd_reg(16'hFF0F, 8'hE2, "held_level_clear");
`endif
    irq_req = 5'h00;
    step();

    // Start and sel together while IDLE: start taken, sel ignored
    wr_reg(16'hFF0F, 8'h10);
    wr_reg(16'hFFFF, 8'h1F);
    dstart = 1'b1; dsel = 1'b1; step(); dstart = 1'b0; dsel = 1'b0;
    chk("start_sel_busy", {15'b0, dbusy}, 16'h1);
    chk("start_sel_no_vv", {15'b0, vvalid}, 16'h0);
    dstart = 1'b1; step(); dstart = 1'b0;
    chk("start_ignored_busy", {15'b0, dbusy}, 16'h1);
    dsel = 1'b1; step(); dsel = 1'b0;
    chk("vec_joypad", vec, 16'h0060);

    // Reset mid-dispatch
    wr_reg(16'hFF0F, 8'h01);
    dstart = 1'b1; step(); dstart = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {15'b0, dbusy}, 16'h0);
    chk("rst_mid_vec", vec, 16'h0000);
    chk("rst_mid_pending", {15'b0, int_pending}, 16'h0);
    rst_n = 1'b1;
    dsel = 1'b1; step(); dsel = 1'b0;
    chk("rst_mid_no_vv", {15'b0, vvalid}, 16'h0);
    rd_reg(16'hFF0F, 8'hE0, "rst_mid_if");
    rd_reg(16'hFFFF, 8'h00, "rst_mid_ie");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
